rgb_fade_controller: RTL and testbench
======================================

# rgb_fade_controller

Parametrised multi-channel PWM LED controller with per-channel target registers and hardware fading. It is the successor to the three-channel RGB intensity front end. Software or switches load a target duty per channel. Each channel's active duty either jumps to the target or ramps toward it in fixed steps at a programmable rate. Duty changes take effect only at PWM period boundaries, so outputs never glitch. The block sits between the board switch/button logic and the LED pins or PMOD test header.

## Interface
Parameters:
- R, 8: duty MSB index; duty width is R+1 bits; PWM period is 2^(R+1) clocks.
- CH, 3: number of channels (CH ≥ 1).
- SEL_W, 2: channel-select width; must satisfy 2^SEL_W ≥ CH.
- TICK_DIV, 100000: clocks per fade tick (≥ 2).
- STEP, 1: duty increment per fade tick (1 ≤ STEP ≤ 2^(R+1)-1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle write strobe for the target register selected by ch_sel
- ch_sel  in  SEL_W  channel index for load
- target  in  R+1  duty value written on load
- fade_en  in  1  1 = ramp toward target; 0 = jump to target
- pwm_out  out  CH  per-channel PWM, bit i = channel i
- busy  out  1  1 while any channel's current duty ≠ its target
- load_err  out  1  one-cycle pulse: load with ch_sel ≥ CH (write ignored)
- period_start  out  1  one-cycle pulse when the PWM counter equals 0

## Operation
- State per channel: tgt (target), cur (current duty), act (compare value used by the PWM).
- Shared counters:
  - pwm_cnt: R+1 bits, free-running 0 → 2^(R+1)-1, then wraps to 0.
  - tick_cnt: counts 0 → TICK_DIV-1 and wraps; the fade tick is the cycle when tick_cnt = TICK_DIV-1.
- Load with ch_sel < CH writes tgt[ch_sel] = target at the clock edge.
  - If fade_en = 0 on that cycle, cur[ch_sel] is also set to target at the same edge.
- Load with ch_sel ≥ CH changes no state and pulses load_err on the next cycle.
- Fade tick with fade_en = 1: every channel with cur ≠ tgt moves by min(STEP, |tgt − cur|) toward tgt.
  - No overshoot and no wrap; cur is clamped exactly at tgt.
- Fade tick with fade_en = 0: every channel is set to cur = tgt. This covers targets loaded while fade_en was 1 and then left behind when fade_en was cleared.
- A load and a tick on the same cycle and channel: the tick step uses the old tgt, and the load still writes tgt. If fade_en = 0, the load value also wins for cur.
- act[i] = cur[i] is latched on the cycle pwm_cnt = 2^(R+1)-1, so the new value applies from the next period_start.
- pwm_out[i] = 1 when pwm_cnt < act[i] (registered output).
  - act = 0 gives constant low.
  - act = 2^(R+1)-1 gives high for all but 1 clock per period.
- busy = OR over i of (cur[i] ≠ tgt[i]), registered.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the caller) clears everything: tgt, cur, act, pwm_cnt, tick_cnt, pwm_out = 0, busy = 0, load_err = 0, period_start = 0.
- A reset mid-fade or mid-period aborts immediately to the values above.
- Jump-mode latency: load at edge t sets cur at t; the new duty is seen on pwm_out starting 1 clock after the next period_start. Worst case is 2^(R+1)+1 clocks.
- Fade latency: a full ramp takes ceil(|Δ|/STEP) ticks, then at most one period before it is visible.
- period_start is high during the cycle pwm_cnt = 0. pwm_out lags the compare by 1 clock.
- load_err is high for exactly 1 cycle, 1 cycle after the bad load.
- No back-pressure: load is accepted every cycle, and back-to-back loads to different channels are all kept.

## Test plan
Use R=3 (period 16), CH=3, SEL_W=2, TICK_DIV=4, STEP=3.
- Reset: hold reset_n=0 during random stimulus → all outputs 0. Release → period_start every 16 clocks, pwm_out=0.
- Jump: fade_en=0, load ch0 with target=5 → busy stays 0. From the next period, pwm_out[0] is high for exactly 5 of every 16 clocks; ch1 and ch2 stay 0.
- Fade: fade_en=1, load ch1 with target=10 → cur[1] steps 3, 6, 9, 10 on successive ticks. busy falls after the 4th tick. Period duty settles at 10/16.
- Down-fade and clamp: ch1 at 10, load target=0 → cur goes 7, 4, 1, 0. Output is constant low once act=0.
- Mid-fade change: while ch2 is fading up to 15, clear fade_en → cur[2] equals tgt at the next tick and busy deasserts.
- Errors and overlap: load with ch_sel=3 → load_err pulses once and no register changes. Load coincident with a tick → the step uses the old target and tgt holds the new value. Reset asserted mid-ramp → everything returns to 0.

Source files
------------

// File: rtl/rgb_fade_controller.sv
// rgb_fade_controller: multi-channel PWM LED driver with per-channel target
// registers and optional hardware fading. Duty updates are applied only at
// PWM period boundaries, so the outputs never glitch.
module rgb_fade_controller #(
    parameter int R        = 8,
    parameter int CH       = 3,
    parameter int SEL_W    = 2,
    parameter int TICK_DIV = 100000,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [R:0]       target,
    input  logic             fade_en,
    output logic [CH-1:0]    pwm_out,
    output logic             busy,
    output logic             load_err,
    output logic             period_start
);

    localparam int W   = R + 1;
    localparam int TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW1 = SEL_W + 1;

    localparam logic [R:0]      CNT_MAX  = '1;
    localparam logic [R:0]      CNT_ONE  = W'(1);
    localparam logic [R:0]      STEP_V   = W'(STEP);
    localparam logic [TW-1:0]   TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   TICK_ONE = TW'(1);
    localparam logic [SEL_W:0]  CH_V     = SW1'(CH);

    logic [R:0]    pwm_cnt;
    logic [TW-1:0] tick_cnt;
    logic [R:0]    tgt     [CH];
    logic [R:0]    cur     [CH];
    logic [R:0]    act     [CH];
    logic [R:0]    tgt_nxt [CH];
    logic [R:0]    cur_nxt [CH];
    logic          tick;
    logic          load_ok;
    logic          busy_nxt;

    // Next target/current duty per channel: the fade step sees the old target,
    // while a jump-mode load overrides whatever the tick would have produced.
    always_comb begin
        tick     = (tick_cnt == TICK_MAX);
        load_ok  = load && ({1'b0, ch_sel} < CH_V);
        busy_nxt = 1'b0;
        for (int i = 0; i < CH; i++) begin
            tgt_nxt[i] = tgt[i];
            cur_nxt[i] = cur[i];
            if (tick) begin
                if (!fade_en) begin
                    cur_nxt[i] = tgt[i];
                end else if (cur[i] < tgt[i]) begin
                    cur_nxt[i] = ((tgt[i] - cur[i]) > STEP_V) ? (cur[i] + STEP_V) : tgt[i];
                end else if (cur[i] > tgt[i]) begin
                    cur_nxt[i] = ((cur[i] - tgt[i]) > STEP_V) ? (cur[i] - STEP_V) : tgt[i];
                end
            end
            if (load_ok && (ch_sel == SEL_W'(i))) begin
                tgt_nxt[i] = target;
                if (!fade_en) begin
                    cur_nxt[i] = target;
                end
            end
            busy_nxt = busy_nxt | (cur_nxt[i] != tgt_nxt[i]);
        end
    end

    // Shared free-running PWM counter and fade tick divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + CNT_ONE;
            tick_cnt <= tick ? '0 : (tick_cnt + TICK_ONE);
        end
    end

    // Channel state; act only follows cur on the last count of a period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
                act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= tgt_nxt[i];
                cur[i] <= cur_nxt[i];
                if (pwm_cnt == CNT_MAX) begin
                    act[i] <= cur[i];
                end
            end
        end
    end

    // Registered outputs: PWM compare, status flags and period marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out      <= '0;
            busy         <= 1'b0;
            load_err     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= (pwm_cnt < act[i]);
            end
            busy         <= busy_nxt;
            load_err     <= load && !load_ok;
            period_start <= (pwm_cnt == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_rgb_fade_controller.sv
// tb_rgb_fade_controller: directed test of jump, fade, clamp, error and
// overlap behaviour with a 16-clock period, tick every 4 clocks, step 3.
module tb_rgb_fade_controller;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [1:0] ch_sel;
    logic [3:0] target;
    logic       fade_en;
    logic [2:0] pwm_out;
    logic       busy;
    logic       load_err;
    logic       period_start;

    int checks = 0;
    int errors = 0;
    int n;
    int c0, c1, c2;

    rgb_fade_controller #(
        .R(3), .CH(3), .SEL_W(2), .TICK_DIV(4), .STEP(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .load(load),
        .ch_sel(ch_sel),
        .target(target),
        .fade_en(fade_en),
        .pwm_out(pwm_out),
        .busy(busy),
        .load_err(load_err),
        .period_start(period_start)
    );

    // 10 ns clock; outputs are sampled on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle load strobe starting at the current falling edge
    task automatic applyStimulus(input logic [1:0] ch, input logic [3:0] val, input logic fade);
        ch_sel  = ch;
        target  = val;
        fade_en = fade;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Advance to the next period_start, counting falling edges (bounded)
    task automatic waitPeriodStart(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!period_start && cycles < 40);
        if (!period_start) checkOutput("period_start_timeout", 32'(cycles), 32'd16);
    endtask

    // Count high cycles per channel over one full period, from a period_start edge
    task automatic measureDuty(output int d0, output int d1, output int d2);
        d0 = 0; d1 = 0; d2 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d0 += int'(pwm_out[0]);
            d1 += int'(pwm_out[1]);
            d2 += int'(pwm_out[2]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        ch_sel  = '0;
        target  = '0;
        fade_en = 1'b0;

        // Reset held while random stimulus is applied
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            load    = 1'($urandom_range(0, 1));
            ch_sel  = 2'($urandom_range(0, 3));
            target  = 4'($urandom_range(0, 15));
            fade_en = 1'($urandom_range(0, 1));
            #1;
            checkOutput("reset_outputs", {26'd0, pwm_out, busy, load_err, period_start}, 32'd0);
        end
        @(negedge clk);
        load    = 1'b0;
        fade_en = 1'b0;
        reset_n = 1'b1;

        waitPeriodStart(n);
        checkOutput("first_period_start", 32'(n), 32'd16);
        measureDuty(c0, c1, c2);
        checkOutput("idle_pwm", 32'(c0 + c1 + c2), 32'd0);
        checkOutput("period_repeat", {31'd0, period_start}, 32'd1);

        // Jump mode: ch0 to 5
        applyStimulus(2'd0, 4'd5, 1'b0);
        checkOutput("jump_busy", {31'd0, busy}, 32'd0);
        waitPeriodStart(n);
        measureDuty(c0, c1, c2);
        checkOutput("jump_ch0_duty", 32'(c0), 32'd5);
        checkOutput("jump_ch1_duty", 32'(c1), 32'd0);
        checkOutput("jump_ch2_duty", 32'(c2), 32'd0);

        // Fade ch1 up to 10: steps 3,6,9,10; act samples 9 then 10
        applyStimulus(2'd1, 4'd10, 1'b1);
        checkOutput("fade_busy_high", {31'd0, busy}, 32'd1);
        waitPeriodStart(n);
        checkOutput("fade_busy_low", {31'd0, busy}, 32'd0);
        measureDuty(c0, c1, c2);
        checkOutput("fade_ch1_mid", 32'(c1), 32'd9);
        checkOutput("fade_ch0_hold", 32'(c0), 32'd5);
        measureDuty(c0, c1, c2);
        checkOutput("fade_ch1_final", 32'(c1), 32'd10);

        // Down-fade with clamp: 7,4,1,0
        applyStimulus(2'd1, 4'd0, 1'b1);
        waitPeriodStart(n);
        measureDuty(c0, c1, c2);
        checkOutput("down_ch1_mid", 32'(c1), 32'd1);
        measureDuty(c0, c1, c2);
        checkOutput("down_ch1_zero", 32'(c1), 32'd0);

        // Mid-fade change: ch2 toward 15, fade_en cleared after two ticks
        applyStimulus(2'd2, 4'd15, 1'b1);
        repeat (7) @(negedge clk);
        fade_en = 1'b0;
        checkOutput("midfade_busy_high", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("midfade_busy_low", {31'd0, busy}, 32'd0);
        waitPeriodStart(n);
        measureDuty(c0, c1, c2);
        checkOutput("midfade_ch2_full", 32'(c2), 32'd15);
        checkOutput("midfade_ch0_hold", 32'(c0), 32'd5);
        checkOutput("midfade_ch1_hold", 32'(c1), 32'd0);

        // Out-of-range channel select
        checkOutput("load_err_idle", {31'd0, load_err}, 32'd0);
        applyStimulus(2'd3, 4'd7, 1'b0);
        checkOutput("load_err_pulse", {31'd0, load_err}, 32'd1);
        @(negedge clk);
        checkOutput("load_err_clear", {31'd0, load_err}, 32'd0);
        checkOutput("load_err_busy", {31'd0, busy}, 32'd0);
        waitPeriodStart(n);
        measureDuty(c0, c1, c2);
        checkOutput("bad_load_ch0", 32'(c0), 32'd5);
        checkOutput("bad_load_ch1", 32'(c1), 32'd0);
        checkOutput("bad_load_ch2", 32'(c2), 32'd15);

        // Load coincident with a tick: step uses old target 12 (3->6), then 3, 2
        applyStimulus(2'd1, 4'd12, 1'b1);
        repeat (6) @(negedge clk);
        applyStimulus(2'd1, 4'd2, 1'b1);
        waitPeriodStart(n);
        measureDuty(c0, c1, c2);
        checkOutput("overlap_ch1_mid", 32'(c1), 32'd3);
        measureDuty(c0, c1, c2);
        checkOutput("overlap_ch1_final", 32'(c1), 32'd2);

        // Reset asserted mid-ramp
        applyStimulus(2'd0, 4'd15, 1'b1);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midramp_reset_pwm", {29'd0, pwm_out}, 32'd0);
        checkOutput("midramp_reset_flags", {29'd0, busy, load_err, period_start}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        waitPeriodStart(n);
        checkOutput("post_reset_period", 32'(n), 32'd16);
        measureDuty(c0, c1, c2);
        checkOutput("post_reset_pwm", 32'(c0 + c1 + c2), 32'd0);
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
